pe_mac_dbw: RTL and testbench

Parametrised next-generation systolic processing element for the tiny-TPU array. It is a signed fixed-point MAC with a double-buffered (shadow/active) weight store and a registered weight-swap path. It has two dataflow modes:
- weight-stationary: psum passes north to south.
- output-stationary: a local accumulator is drained south on command.
West-to-east and north-to-south forwarding is registered, one hop per cycle, so tiles of the array chain directly.

---
 rtl/pe_mac_dbw_pkg.sv | 17 +
 rtl/pe_mac_dbw_fxp_narrow.sv | 32 +++
 rtl/pe_mac_dbw.sv | 137 +++++++++++++
 tb/tb_pe_mac_dbw.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/pe_mac_dbw_pkg.sv
// Shared types and constants for the pe_mac_dbw processing element.
// Saturation limits apply when PE_SAT_EN is defined; wrap is the default.
package pe_pkg;

  localparam int PE_DW = 16;

  typedef logic signed [PE_DW-1:0] data_t;

  typedef enum logic {
    PE_MODE_WS = 1'b0,
    PE_MODE_OS = 1'b1
  } pe_mode_e;

  localparam data_t SAT_MAX = {1'b0, {(PE_DW-1){1'b1}}};
  localparam data_t SAT_MIN = {1'b1, {(PE_DW-1){1'b0}}};

endpackage

// File: rtl/pe_mac_dbw_fxp_narrow.sv
// Combinational signed narrower with overflow detect.
// PE_SAT_EN defined: clamp to the output range; undefined: two's-complement wrap.
module fxp_narrow #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 16
) (
  input  logic [IN_W-1:0]  i_val,
  output logic [OUT_W-1:0] o_val,
  output logic             o_ovf
);

  logic [IN_W-OUT_W:0] w_top;
  logic                w_ovf;

  // Value fits only if every bit above the output sign bit matches it.
  assign w_top = i_val[IN_W-1:OUT_W-1];
  assign w_ovf = ~((&w_top) | ~(|w_top));
  assign o_ovf = w_ovf;

`ifdef PE_SAT_EN
  always_comb begin
    o_val = i_val[OUT_W-1:0];
    if (w_ovf) begin
      o_val = i_val[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                            : {1'b0, {(OUT_W-1){1'b1}}};
    end
  end
`else
  assign o_val = i_val[OUT_W-1:0];
`endif

endmodule

// File: rtl/pe_mac_dbw.sv
// Systolic MAC processing element with shadow/active weight double buffer,
// WS and OS dataflow modes. Narrowing mode selected by PE_SAT_EN.
module pe_mac_dbw
  import pe_pkg::*;
#(
  parameter int DATA_WIDTH = PE_DW,
  parameter int FRAC_BITS  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pe_enabled,
  input  logic                  pe_mode_in,
  input  logic [DATA_WIDTH-1:0] pe_psum_in,
  input  logic [DATA_WIDTH-1:0] pe_weight_in,
  input  logic                  pe_accept_w_in,
  input  logic [DATA_WIDTH-1:0] pe_input_in,
  input  logic                  pe_valid_in,
  input  logic                  pe_switch_in,
  input  logic                  pe_drain_in,
  output logic [DATA_WIDTH-1:0] pe_psum_out,
  output logic                  pe_psum_valid_out,
  output logic [DATA_WIDTH-1:0] pe_weight_out,
  output logic                  pe_accept_w_out,
  output logic [DATA_WIDTH-1:0] pe_input_out,
  output logic                  pe_valid_out,
  output logic                  pe_switch_out,
  output logic                  pe_drain_out,
  output logic                  pe_ovf_out
);

  localparam int W = DATA_WIDTH;

  logic [W-1:0]   r_shadow;
  logic [W-1:0]   r_active;
  logic [W-1:0]   r_acc;

  pe_mode_e       w_mode;
  logic [W-1:0]   w_w_eff;
  logic [2*W-1:0] w_mul_a;
  logic [2*W-1:0] w_mul_b;
  logic [2*W-1:0] w_prod_full;
  logic [2*W-1:0] w_prod_shift;
  logic [W-1:0]   w_prod_n;
  logic           w_prod_ovf;
  logic [W-1:0]   w_addend;
  logic [W:0]     w_sum;
  logic [W-1:0]   w_sum_n;
  logic           w_sum_ovf;
  logic           w_ovf_evt;

  assign w_mode = pe_mode_e'(pe_mode_in);

  // Switch on this edge already multiplies with the shadow weight.
  assign w_w_eff      = pe_switch_in ? r_shadow : r_active;
  assign w_mul_a      = {{W{w_w_eff[W-1]}}, w_w_eff};
  assign w_mul_b      = {{W{pe_input_in[W-1]}}, pe_input_in};
  assign w_prod_full  = w_mul_a * w_mul_b;
  assign w_prod_shift = $signed(w_prod_full) >>> FRAC_BITS;

  fxp_narrow #(.IN_W(2*W), .OUT_W(W)) u_narrow_prod (
    .i_val (w_prod_shift),
    .o_val (w_prod_n),
    .o_ovf (w_prod_ovf)
  );

  // A drain restarts the accumulator from the current product alone.
  always_comb begin
    w_addend = pe_psum_in;
    if (w_mode == PE_MODE_OS) begin
      w_addend = pe_drain_in ? '0 : r_acc;
    end
  end

  assign w_sum = {w_prod_n[W-1], w_prod_n} + {w_addend[W-1], w_addend};

  fxp_narrow #(.IN_W(W+1), .OUT_W(W)) u_narrow_sum (
    .i_val (w_sum),
    .o_val (w_sum_n),
    .o_ovf (w_sum_ovf)
  );

  assign w_ovf_evt = pe_enabled & pe_valid_in & (w_prod_ovf | w_sum_ovf);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow          <= '0;
      r_active          <= '0;
      r_acc             <= '0;
      pe_psum_out       <= '0;
      pe_psum_valid_out <= 1'b0;
      pe_weight_out     <= '0;
      pe_accept_w_out   <= 1'b0;
      pe_input_out      <= '0;
      pe_valid_out      <= 1'b0;
      pe_switch_out     <= 1'b0;
      pe_drain_out      <= 1'b0;
      pe_ovf_out        <= 1'b0;
    end else if (!pe_enabled) begin
      pe_psum_out       <= '0;
      pe_psum_valid_out <= 1'b0;
      pe_weight_out     <= '0;
      pe_accept_w_out   <= 1'b0;
      pe_input_out      <= '0;
      pe_valid_out      <= 1'b0;
      pe_switch_out     <= 1'b0;
      pe_drain_out      <= 1'b0;
    end else begin
      pe_valid_out      <= pe_valid_in;
      pe_switch_out     <= pe_switch_in;
      pe_drain_out      <= pe_drain_in;
      pe_accept_w_out   <= pe_accept_w_in;
      pe_weight_out     <= pe_accept_w_in ? pe_weight_in : '0;
      pe_psum_out       <= '0;
      pe_psum_valid_out <= 1'b0;

      if (pe_accept_w_in) r_shadow <= pe_weight_in;
      if (pe_switch_in)   r_active <= r_shadow;
      if (pe_valid_in)    pe_input_out <= pe_input_in;
      if (w_ovf_evt)      pe_ovf_out <= 1'b1;

      if (w_mode == PE_MODE_WS) begin
        if (pe_valid_in) begin
          pe_psum_out       <= w_sum_n;
          pe_psum_valid_out <= 1'b1;
        end
      end else begin
        if (pe_drain_in) begin
          pe_psum_out       <= r_acc;
          pe_psum_valid_out <= 1'b1;
          r_acc             <= '0;
        end
        if (pe_valid_in) r_acc <= w_sum_n;
      end
    end
  end

endmodule

// File: tb/tb_pe_mac_dbw.sv
// Directed self-checking bench for pe_mac_dbw (Q8.8, 16-bit).
// Expected values are hand-computed; overflow result depends on PE_SAT_EN.
module tb_pe_mac_dbw;
  import pe_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        pe_enabled;
  logic        pe_mode_in;
  logic [15:0] pe_psum_in;
  logic [15:0] pe_weight_in;
  logic        pe_accept_w_in;
  logic [15:0] pe_input_in;
  logic        pe_valid_in;
  logic        pe_switch_in;
  logic        pe_drain_in;
  logic [15:0] pe_psum_out;
  logic        pe_psum_valid_out;
  logic [15:0] pe_weight_out;
  logic        pe_accept_w_out;
  logic [15:0] pe_input_out;
  logic        pe_valid_out;
  logic        pe_switch_out;
  logic        pe_drain_out;
  logic        pe_ovf_out;

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_ovf_res;

  always #5 clk = ~clk;

  pe_mac_dbw #(.DATA_WIDTH(16), .FRAC_BITS(8)) dut (
    .clk               (clk),
    .rst               (rst),
    .pe_enabled        (pe_enabled),
    .pe_mode_in        (pe_mode_in),
    .pe_psum_in        (pe_psum_in),
    .pe_weight_in      (pe_weight_in),
    .pe_accept_w_in    (pe_accept_w_in),
    .pe_input_in       (pe_input_in),
    .pe_valid_in       (pe_valid_in),
    .pe_switch_in      (pe_switch_in),
    .pe_drain_in       (pe_drain_in),
    .pe_psum_out       (pe_psum_out),
    .pe_psum_valid_out (pe_psum_valid_out),
    .pe_weight_out     (pe_weight_out),
    .pe_accept_w_out   (pe_accept_w_out),
    .pe_input_out      (pe_input_out),
    .pe_valid_out      (pe_valid_out),
    .pe_switch_out     (pe_switch_out),
    .pe_drain_out      (pe_drain_out),
    .pe_ovf_out        (pe_ovf_out)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
`ifdef PE_SAT_EN
    exp_ovf_res = SAT_MAX;
`else
    exp_ovf_res = 16'h7EFF;
`endif
    rst = 1'b1; pe_enabled = 1'b1; pe_mode_in = 1'b0;
    pe_psum_in = '0; pe_weight_in = '0; pe_accept_w_in = 1'b0;
    pe_input_in = '0; pe_valid_in = 1'b0; pe_switch_in = 1'b0; pe_drain_in = 1'b0;
    #12;
    chk("rst_psum", pe_psum_out, 16'h0000);
    chk("rst_psv", {15'd0, pe_psum_valid_out}, 16'd0);
    chk("rst_ovf", {15'd0, pe_ovf_out}, 16'd0);
    rst = 1'b0;

    // WS MAC with same-cycle swap
    pe_accept_w_in = 1'b1; pe_weight_in = 16'h0200;
    step();
    chk("t1_wout", pe_weight_out, 16'h0200);
    chk("t1_acc_out", {15'd0, pe_accept_w_out}, 16'd1);
    pe_accept_w_in = 1'b0; pe_weight_in = '0;
    pe_switch_in = 1'b1; pe_valid_in = 1'b1; pe_input_in = 16'h0180; pe_psum_in = 16'h0100;
    step();
    chk("t1_psum", pe_psum_out, 16'h0400);
    chk("t1_psv", {15'd0, pe_psum_valid_out}, 16'd1);
    chk("t1_in_out", pe_input_out, 16'h0180);
    chk("t1_sw_out", {15'd0, pe_switch_out}, 16'd1);
    chk("t1_wout0", pe_weight_out, 16'h0000);

    // Double buffer
    pe_switch_in = 1'b0; pe_valid_in = 1'b0;
    pe_accept_w_in = 1'b1; pe_weight_in = 16'h0100;
    step();
    chk("t2_psv_idle", {15'd0, pe_psum_valid_out}, 16'd0);
    chk("t2_in_hold", pe_input_out, 16'h0180);
    pe_accept_w_in = 1'b0; pe_switch_in = 1'b1;
    step();
    pe_switch_in = 1'b0;
    pe_accept_w_in = 1'b1; pe_weight_in = 16'h0300;
    pe_valid_in = 1'b1; pe_input_in = 16'h0200; pe_psum_in = 16'h0000;
    step();
    chk("t2_old_w_a", pe_psum_out, 16'h0200);
    pe_accept_w_in = 1'b0;
    step();
    chk("t2_old_w_b", pe_psum_out, 16'h0200);
    pe_switch_in = 1'b1;
    step();
    chk("t2_swap", pe_psum_out, 16'h0600);

    // Negative values and floor rounding
    pe_switch_in = 1'b0; pe_valid_in = 1'b0;
    pe_accept_w_in = 1'b1; pe_weight_in = 16'h0100;
    step();
    pe_accept_w_in = 1'b0; pe_switch_in = 1'b1; pe_valid_in = 1'b1; pe_input_in = 16'hFE80;
    step();
    chk("neg_psum", pe_psum_out, 16'hFE80);
    pe_switch_in = 1'b0; pe_accept_w_in = 1'b1; pe_weight_in = 16'h0080;
    step();
    pe_accept_w_in = 1'b0; pe_switch_in = 1'b1; pe_input_in = 16'hFFFF;
    step();
    chk("floor_psum", pe_psum_out, 16'hFFFF);
    chk("no_ovf", {15'd0, pe_ovf_out}, 16'd0);

    // OS accumulate and drain
    pe_switch_in = 1'b0; pe_valid_in = 1'b0;
    pe_accept_w_in = 1'b1; pe_weight_in = 16'h0100;
    step();
    pe_accept_w_in = 1'b0; pe_switch_in = 1'b1;
    step();
    pe_switch_in = 1'b0; pe_mode_in = 1'b1; pe_valid_in = 1'b1; pe_input_in = 16'h0100;
    step();
    chk("t3_psv_acc", {15'd0, pe_psum_valid_out}, 16'd0);
    step();
    step();
    pe_valid_in = 1'b0; pe_drain_in = 1'b1;
    step();
    chk("t3_drain", pe_psum_out, 16'h0300);
    chk("t3_drain_v", {15'd0, pe_psum_valid_out}, 16'd1);
    chk("t3_drain_out", {15'd0, pe_drain_out}, 16'd1);
    pe_drain_in = 1'b0; pe_valid_in = 1'b1; pe_input_in = 16'h0100;
    step();
    chk("t3_once", {15'd0, pe_psum_valid_out}, 16'd0);
    pe_drain_in = 1'b1; pe_input_in = 16'h0200;
    step();
    chk("t3_dv_old", pe_psum_out, 16'h0100);
    pe_valid_in = 1'b0;
    step();
    chk("t3_dv_new", pe_psum_out, 16'h0200);
    pe_mode_in = 1'b0;
    step();
    chk("ws_drain_ign", {15'd0, pe_psum_valid_out}, 16'd0);

    // Overflow
    pe_drain_in = 1'b0;
    pe_accept_w_in = 1'b1; pe_weight_in = 16'h7FFF;
    step();
    pe_accept_w_in = 1'b0; pe_switch_in = 1'b1; pe_valid_in = 1'b1;
    pe_input_in = 16'h7FFF; pe_psum_in = 16'h7FFF;
    step();
    chk("t4_psum", pe_psum_out, exp_ovf_res);
    chk("t4_ovf", {15'd0, pe_ovf_out}, 16'd1);
    pe_switch_in = 1'b0; pe_valid_in = 1'b0; pe_psum_in = 16'h0000;
    step();
    chk("t4_ovf_sticky", {15'd0, pe_ovf_out}, 16'd1);

    // Enable gating
    pe_accept_w_in = 1'b1; pe_weight_in = 16'h0100;
    step();
    pe_accept_w_in = 1'b0; pe_switch_in = 1'b1;
    step();
    pe_switch_in = 1'b0; pe_mode_in = 1'b1; pe_valid_in = 1'b1; pe_input_in = 16'h0100;
    step();
    pe_enabled = 1'b0;
    pe_accept_w_in = 1'b1; pe_weight_in = 16'h0500; pe_switch_in = 1'b1; pe_drain_in = 1'b1;
    pe_psum_in = 16'h0100;
    step();
    chk("t5_psum", pe_psum_out, 16'h0000);
    chk("t5_psv", {15'd0, pe_psum_valid_out}, 16'd0);
    chk("t5_wout", pe_weight_out, 16'h0000);
    chk("t5_in_out", pe_input_out, 16'h0000);
    chk("t5_flags", {12'd0, pe_valid_out, pe_switch_out, pe_drain_out, pe_accept_w_out}, 16'd0);
    step();
    chk("t5_psum2", pe_psum_out, 16'h0000);
    pe_enabled = 1'b1; pe_accept_w_in = 1'b0; pe_switch_in = 1'b0; pe_valid_in = 1'b0;
    pe_psum_in = 16'h0000;
    step();
    chk("t5_acc_kept", pe_psum_out, 16'h0100);
    pe_drain_in = 1'b0; pe_mode_in = 1'b0; pe_switch_in = 1'b1; pe_valid_in = 1'b1;
    pe_input_in = 16'h0200;
    step();
    chk("t5_shadow_kept", pe_psum_out, 16'h0200);

    // Async reset mid-accumulate
    pe_switch_in = 1'b0; pe_mode_in = 1'b1; pe_input_in = 16'h0100;
    step();
    step();
    chk("t6_pre_vout", {15'd0, pe_valid_out}, 16'd1);
    #3;
    rst = 1'b1;
    #1;
    chk("t6_vout", {15'd0, pe_valid_out}, 16'd0);
    chk("t6_in_out", pe_input_out, 16'h0000);
    chk("t6_ovf", {15'd0, pe_ovf_out}, 16'd0);
    rst = 1'b0;
    pe_valid_in = 1'b0; pe_drain_in = 1'b1;
    step();
    chk("t6_acc0", pe_psum_out, 16'h0000);
    chk("t6_acc0_v", {15'd0, pe_psum_valid_out}, 16'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
